// File: rtl/mpu_pkg.sv
// -----------------------------------------------------------------------------
// mpu_pkg
// Shared definitions for the BRAM command responder: command encodings
// (identical to host_instruction[1:0]), the responder FSM state type, the
// default geometry, and a helper that maps a command to its first state.
// -----------------------------------------------------------------------------
package mpu_pkg;

  localparam int DEFAULT_DEPTH  = 512;
  localparam int DEFAULT_DATA_W = 16;

  localparam logic [1:0] CMD_LOAD   = 2'b00;
  localparam logic [1:0] CMD_COPY   = 2'b01;
  localparam logic [1:0] CMD_UNLOAD = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    RD_HOLD = 3'd4,
    CLR     = 3'd5,
    DONE    = 3'd6
  } state_t;

  // First state entered when a command is accepted in IDLE.
  function automatic state_t cmd_entry_state(input logic [1:0] c);
    state_t s;
    case (c)
      CMD_LOAD, CMD_COPY: s = WR;
      CMD_UNLOAD:         s = RD_REQ;
      CMD_CLEAR:          s = CLR;
      default:            s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mpu_addr_counter.sv
// -----------------------------------------------------------------------------
// mpu_addr_counter
// Word address counter for one BRAM command.
//   clk, reset  : clock, asynchronous active-low reset
//   clr         : load 0 (command accepted)
//   inc         : advance by one word
//   addr        : current word address
//   last        : addr == DEPTH-1
// The counter saturates at DEPTH-1 so it can never run past the array or
// wrap inside a command, even if inc is held on the final word.
// -----------------------------------------------------------------------------
module mpu_addr_counter #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Address register: clear has priority, increment stops at the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc && (addr != LAST_ADDR)) begin
      addr <= addr + ADDR_W'(1);
    end else begin
      addr <= addr;
    end
  end

  assign last = (addr == LAST_ADDR);

endmodule

// File: rtl/bram_cmd_responder.sv
// -----------------------------------------------------------------------------
// bram_cmd_responder
// Executes one MPU BRAM command at a time: LOAD (host stream -> BRAM),
// COPY (peer BRAM stream -> BRAM), UNLOAD (BRAM -> host stream with
// ready/valid hold) and CLEAR (zero fill).
//   clk, reset                  : clock, asynchronous active-low reset
//   start, cmd                  : command strobe and code, sampled in IDLE
//   host_wr_data/valid          : LOAD source stream
//   peer_data/valid             : COPY source stream
//   host_rd_data/valid/ready    : UNLOAD stream to the host
//   mem_addr/wr_en/wr_data      : BRAM port (registered)
//   mem_rd_data                 : BRAM read data, one cycle after mem_addr
//   busy, done, err             : not idle, completion pulse, rejected start
// All outputs are registered. mem_addr is loaded on entry to RD_REQ so the
// BRAM sees the address for the whole RD_REQ cycle and returns the word
// during RD_DATA.
// -----------------------------------------------------------------------------
module bram_cmd_responder
  import mpu_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_wr_valid,
  input  logic [DATA_W-1:0] peer_data,
  input  logic              peer_valid,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_rd_valid,
  input  logic              host_rd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state_r;
  logic [1:0]          cmd_r;
  logic [ADDR_W-1:0]   addr_s;
  logic                last_s;
  logic                cnt_clr_s;
  logic                cnt_inc_s;
  logic                sel_valid_s;
  logic [DATA_W-1:0]   sel_data_s;

  mpu_addr_counter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .addr  (addr_s),
    .last  (last_s)
  );

  // Write-source select: COPY takes the peer stream, LOAD the host stream.
  always_comb begin
    if (cmd_r == CMD_COPY) begin
      sel_valid_s = peer_valid;
      sel_data_s  = peer_data;
    end else begin
      sel_valid_s = host_wr_valid;
      sel_data_s  = host_wr_data;
    end
  end

  // Counter control: advance once per consumed/produced word.
  always_comb begin
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      IDLE:    cnt_clr_s = start;
      WR:      cnt_inc_s = sel_valid_s;
      CLR:     cnt_inc_s = 1'b1;
      RD_HOLD: cnt_inc_s = host_rd_ready;
      default: begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
      end
    endcase
  end

  // Command FSM with registered BRAM, stream and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cmd_r         <= CMD_LOAD;
      mem_addr      <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_data   <= '0;
      host_rd_data  <= '0;
      host_rd_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      // A start outside IDLE is only reported; it never disturbs the command.
      err       <= start && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            cmd_r    <= cmd;
            state_r  <= cmd_entry_state(cmd);
            mem_addr <= '0;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        WR: begin
          if (sel_valid_s) begin
            mem_wr_en   <= 1'b1;
            mem_addr    <= addr_s;
            mem_wr_data <= sel_data_s;
            if (last_s) begin
              state_r <= DONE;
            end
          end
        end
        CLR: begin
          mem_wr_en   <= 1'b1;
          mem_addr    <= addr_s;
          mem_wr_data <= '0;
          if (last_s) begin
            state_r <= DONE;
          end
        end
        RD_REQ: begin
          state_r <= RD_DATA;
        end
        RD_DATA: begin
          host_rd_data  <= mem_rd_data;
          host_rd_valid <= 1'b1;
          state_r       <= RD_HOLD;
        end
        RD_HOLD: begin
          if (host_rd_ready) begin
            host_rd_valid <= 1'b0;
            if (last_s) begin
              state_r <= DONE;
            end else begin
              // Present the next address on entry to RD_REQ.
              state_r  <= RD_REQ;
              mem_addr <= addr_s + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
